// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters and rr_grant_arbiter.
// master: requester side (drives request/acknowledge).
// slave : arbiter side (drives grant/grant_valid/grant_encoded/timeout).
interface rr_grant_arbiter_if #(
    parameter int PORTS = 4
);
    localparam int EW = $clog2(PORTS);

    logic [PORTS-1:0] request;
    logic [PORTS-1:0] acknowledge;
    logic [PORTS-1:0] grant;
    logic             grant_valid;
    logic [EW-1:0]    grant_encoded;
    logic             timeout;

    modport master (
        output request,
        output acknowledge,
        input  grant,
        input  grant_valid,
        input  grant_encoded,
        input  timeout
    );

    modport slave (
        input  request,
        input  acknowledge,
        output grant,
        output grant_valid,
        output grant_encoded,
        output timeout
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Registered N-way arbiter with fixed or round-robin priority.
// A grant is held until its owner releases it (acknowledge, or request drop
// when BLOCK_ACK=0); release and re-arbitration share one edge.
// Optional macro ARB_HOLD_TIMEOUT_EN: force a release after TIMEOUT_CYCLES
// held cycles and pulse timeout; without it timeout is tied low.

// Priority encoder; input is zero-padded to a power of two so padded lanes
// can never win.
module priority_encoder #(
    parameter int WIDTH             = 4,
    parameter int LSB_HIGH_PRIORITY = 0
) (
    input  logic [WIDTH-1:0]         input_unencoded,
    output logic                     output_valid,
    output logic [$clog2(WIDTH)-1:0] output_encoded
);
    localparam int EW = $clog2(WIDTH);
    localparam int PW = 2 ** EW;

    logic [PW-1:0] padded;
    logic          found;

    // Zero-extend the request vector to the padded width.
    always_comb begin
        padded             = '0;
        padded[WIDTH-1:0]  = input_unencoded;
    end

    // Pick the lowest set index (LSB high) or the highest set index.
    always_comb begin
        output_valid   = |padded;
        output_encoded = '0;
        found          = 1'b0;
        for (int unsigned i = 0; i < PW; i++) begin
            if (padded[i]) begin
                if (LSB_HIGH_PRIORITY != 0) begin
                    if (!found) begin
                        output_encoded = EW'(i);
                        found          = 1'b1;
                    end
                end else begin
                    output_encoded = EW'(i);
                end
            end
        end
    end
endmodule

module rr_grant_arbiter #(
    parameter int PORTS             = 4,
    parameter int ROUND_ROBIN       = 1,
    parameter int BLOCK_ACK         = 1,
    parameter int LSB_HIGH_PRIORITY = 0,
    parameter int TIMEOUT_CYCLES    = 256
) (
    input logic              clk,
    input logic              rstn,
    rr_grant_arbiter_if.slave arb
);
    localparam int EW = $clog2(PORTS);

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t           state_q, state_d;
    logic [PORTS-1:0] grant_q, grant_d;
    logic [PORTS-1:0] mask_q, mask_d;
    logic             valid_q, valid_d;
    logic [EW-1:0]    enc_q, enc_d;

    logic [PORTS-1:0] req_masked;
    logic             m_valid, r_valid;
    logic [EW-1:0]    m_idx, r_idx, win_idx;
    logic             owner_release;
    logic             forced;
    logic             release_any;
    logic             load_grant;

    assign req_masked = arb.request & mask_q;

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
    ) u_enc_masked (
        .input_unencoded (req_masked),
        .output_valid    (m_valid),
        .output_encoded  (m_idx)
    );

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
    ) u_enc_raw (
        .input_unencoded (arb.request),
        .output_valid    (r_valid),
        .output_encoded  (r_idx)
    );

    // An empty mask yields no masked winner and falls back to the raw order.
    assign win_idx = ((ROUND_ROBIN != 0) && m_valid) ? m_idx : r_idx;

    assign owner_release = (BLOCK_ACK != 0) ? arb.acknowledge[enc_q]
                                            : !arb.request[enc_q];
    assign release_any   = owner_release || forced;

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] hold_q;
    logic          timeout_q;

    assign forced = (state_q == GRANTED) && !owner_release &&
                    (hold_q == CW'(TIMEOUT_CYCLES - 1));

    // Count held cycles; clear on any new grant or when going idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= forced;
            if (load_grant || (state_d == IDLE)) begin
                hold_q <= '0;
            end else begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

    assign arb.timeout = timeout_q;
`else
    assign forced      = 1'b0;
    assign arb.timeout = 1'b0;
`endif

    // Next-state, grant and mask computation.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        valid_d    = valid_q;
        enc_d      = enc_q;
        mask_d     = mask_q;
        load_grant = 1'b0;

        case (state_q)
            IDLE: begin
                if (r_valid) begin
                    load_grant = 1'b1;
                end
            end
            GRANTED: begin
                if (release_any) begin
                    if (r_valid) begin
                        load_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                        enc_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                enc_d   = '0;
            end
        endcase

        if (load_grant) begin
            state_d          = GRANTED;
            valid_d          = 1'b1;
            enc_d            = win_idx;
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            if (ROUND_ROBIN != 0) begin
                for (int unsigned i = 0; i < PORTS; i++) begin
                    if (LSB_HIGH_PRIORITY != 0) begin
                        mask_d[i] = (i > 32'(win_idx));
                    end else begin
                        mask_d[i] = (i < 32'(win_idx));
                    end
                end
            end
        end
    end

    // State, registered outputs and round-robin mask.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            enc_q   <= '0;
            mask_q  <= '1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            enc_q   <= enc_d;
            mask_q  <= mask_d;
        end
    end

    assign arb.grant         = grant_q;
    assign arb.grant_valid   = valid_q;
    assign arb.grant_encoded = enc_q;
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter over three parameter sets:
//  a: round robin, LSB high priority, release on acknowledge, timeout 8
//  b: fixed priority, MSB high priority, release on acknowledge
//  c: round robin, MSB high priority, release on request drop
module tb_rr_grant_arbiter;
    logic clk;
    logic rstn;
    int   n_vec;
    int   n_err;

    rr_grant_arbiter_if #(.PORTS(4)) if_a ();
    rr_grant_arbiter_if #(.PORTS(4)) if_b ();
    rr_grant_arbiter_if #(.PORTS(4)) if_c ();

    rr_grant_arbiter #(
        .PORTS(4), .ROUND_ROBIN(1), .BLOCK_ACK(1),
        .LSB_HIGH_PRIORITY(1), .TIMEOUT_CYCLES(8)
    ) dut_a (.clk(clk), .rstn(rstn), .arb(if_a.slave));

    rr_grant_arbiter #(
        .PORTS(4), .ROUND_ROBIN(0), .BLOCK_ACK(1),
        .LSB_HIGH_PRIORITY(0), .TIMEOUT_CYCLES(8)
    ) dut_b (.clk(clk), .rstn(rstn), .arb(if_b.slave));

    rr_grant_arbiter #(
        .PORTS(4), .ROUND_ROBIN(1), .BLOCK_ACK(0),
        .LSB_HIGH_PRIORITY(0), .TIMEOUT_CYCLES(8)
    ) dut_c (.clk(clk), .rstn(rstn), .arb(if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [3:0] g,
                         input logic v, input logic [1:0] e);
        check({tag, ".a.grant"}, 32'(if_a.grant), 32'(g));
        check({tag, ".a.valid"}, 32'(if_a.grant_valid), 32'(v));
        check({tag, ".a.enc"}, 32'(if_a.grant_encoded), 32'(e));
    endtask

    task automatic chk_b(input string tag, input logic [3:0] g,
                         input logic v, input logic [1:0] e);
        check({tag, ".b.grant"}, 32'(if_b.grant), 32'(g));
        check({tag, ".b.valid"}, 32'(if_b.grant_valid), 32'(v));
        check({tag, ".b.enc"}, 32'(if_b.grant_encoded), 32'(e));
    endtask

    task automatic chk_c(input string tag, input logic [3:0] g,
                         input logic v, input logic [1:0] e);
        check({tag, ".c.grant"}, 32'(if_c.grant), 32'(g));
        check({tag, ".c.valid"}, 32'(if_c.grant_valid), 32'(v));
        check({tag, ".c.enc"}, 32'(if_c.grant_encoded), 32'(e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] rr_order [5];
        rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        n_vec = 0;
        n_err = 0;
        rstn  = 1'b0;
        if_a.request = '0; if_a.acknowledge = '0;
        if_b.request = '0; if_b.acknowledge = '0;
        if_c.request = '0; if_c.acknowledge = '0;

        // Reset state
        step();
        step();
        chk_a("reset", 4'b0000, 1'b0, 2'd0);
        chk_b("reset", 4'b0000, 1'b0, 2'd0);
        check("reset.a.timeout", 32'(if_a.timeout), 32'd0);
        rstn = 1'b1;
        step();
        chk_a("idle_no_req", 4'b0000, 1'b0, 2'd0);

        // Case 1: single request, one-cycle latency, ack releases
        if_a.request = 4'b0100;
        step();
        chk_a("c1_grant", 4'b0100, 1'b1, 2'd2);
        if_a.request = 4'b0000;
        if_a.acknowledge = 4'b0100;
        step();
        chk_a("c1_release", 4'b0000, 1'b0, 2'd0);
        if_a.acknowledge = 4'b0000;

        // Case 4: request drop and foreign ack do not release (mask 1000)
        if_a.request = 4'b0100;
        step();
        chk_a("c4_grant", 4'b0100, 1'b1, 2'd2);
        if_a.request = 4'b0000;
        if_a.acknowledge = 4'b0010;
        step();
        chk_a("c4_foreign_ack", 4'b0100, 1'b1, 2'd2);
        if_a.acknowledge = 4'b0000;
        step();
        chk_a("c4_dropped_req", 4'b0100, 1'b1, 2'd2);
        if_a.acknowledge = 4'b0100;
        step();
        chk_a("c4_owner_ack", 4'b0000, 1'b0, 2'd0);
        if_a.acknowledge = 4'b0000;

        // Case 5: async reset mid-grant; afterwards unmasked order applies
        // (mask 1000 here: 0101 grants port 0, leaving mask 1110)
        if_a.request = 4'b0101;
        step();
        chk_a("c5_pre", 4'b0001, 1'b1, 2'd0);
        #3 rstn = 1'b0;
        #1;
        chk_a("c5_async", 4'b0000, 1'b0, 2'd0);
        #1 rstn = 1'b1;
        step();
        chk_a("c5_unmasked", 4'b0001, 1'b1, 2'd0);
        if_a.request = 4'b0000;
        if_a.acknowledge = 4'b0001;
        step();
        chk_a("c5_release", 4'b0000, 1'b0, 2'd0);
        if_a.acknowledge = 4'b0000;

        // Case 2: round robin 0,1,2,3,0 from a fresh mask, no idle gaps
        rstn = 1'b0;
        #2 rstn = 1'b1;
        if_a.request = 4'b1111;
        step();
        chk_a("c2_rr0", rr_order[0], 1'b1, 2'd0);
        for (int i = 1; i < 5; i++) begin
            if_a.acknowledge = rr_order[i-1];
            step();
            chk_a($sformatf("c2_rr%0d", i), rr_order[i], 1'b1, 2'(i % 4));
        end
        // Ack plus held request by sole requester: owner re-wins at once
        if_a.request = 4'b0001;
        if_a.acknowledge = 4'b0001;
        step();
        chk_a("ack_req_same", 4'b0001, 1'b1, 2'd0);
        if_a.request = 4'b0000;
        if_a.acknowledge = 4'b0000;
        step();
        chk_a("drop_keeps", 4'b0001, 1'b1, 2'd0);
        if_a.acknowledge = 4'b0001;
        step();
        chk_a("drop_then_ack", 4'b0000, 1'b0, 2'd0);
        if_a.acknowledge = 4'b0000;

        // Case 3: fixed priority, MSB high: port 1 wins every time
        chk_b("c3_idle", 4'b0000, 1'b0, 2'd0);
        if_b.request = 4'b0011;
        step();
        chk_b("c3_g0", 4'b0010, 1'b1, 2'd1);
        for (int i = 1; i < 4; i++) begin
            if_b.acknowledge = 4'b0010;
            step();
            chk_b($sformatf("c3_g%0d", i), 4'b0010, 1'b1, 2'd1);
        end
        if_b.request = 4'b0000;
        step();
        chk_b("c3_release", 4'b0000, 1'b0, 2'd0);
        if_b.acknowledge = 4'b0000;

        // Release on request drop; acknowledge ignored in this mode
        if_c.request = 4'b0110;
        step();
        chk_c("rq_grant", 4'b0100, 1'b1, 2'd2);
        if_c.acknowledge = 4'b0100;
        step();
        chk_c("rq_ack_ignored", 4'b0100, 1'b1, 2'd2);
        if_c.acknowledge = 4'b0000;
        if_c.request = 4'b0010;
        step();
        chk_c("rq_handoff", 4'b0010, 1'b1, 2'd1);
        if_c.request = 4'b0000;
        step();
        chk_c("rq_idle", 4'b0000, 1'b0, 2'd0);

        // Case 6: hold timeout (mask 1110 here, port 1 wins)
        if_a.request = 4'b0010;
        step();
        chk_a("c6_grant", 4'b0010, 1'b1, 2'd1);
        if_a.request = 4'b1010;
        for (int i = 1; i < 8; i++) begin
            step();
            check($sformatf("c6_hold%0d.grant", i), 32'(if_a.grant), 32'h2);
            check($sformatf("c6_hold%0d.tmo", i), 32'(if_a.timeout), 32'd0);
        end
        step();
`ifdef ARB_HOLD_TIMEOUT_EN
        chk_a("c6_forced", 4'b1000, 1'b1, 2'd3);
        check("c6_tmo_pulse", 32'(if_a.timeout), 32'd1);
        step();
        chk_a("c6_after", 4'b1000, 1'b1, 2'd3);
        check("c6_tmo_end", 32'(if_a.timeout), 32'd0);
        if_a.request = 4'b0000;
        if_a.acknowledge = 4'b1000;
`else
        chk_a("c6_no_timeout", 4'b0010, 1'b1, 2'd1);
        check("c6_tmo_tied", 32'(if_a.timeout), 32'd0);
        step();
        chk_a("c6_still_held", 4'b0010, 1'b1, 2'd1);
        check("c6_tmo_tied2", 32'(if_a.timeout), 32'd0);
        if_a.request = 4'b0000;
        if_a.acknowledge = 4'b0010;
`endif
        step();
        chk_a("c6_idle", 4'b0000, 1'b0, 2'd0);
        if_a.acknowledge = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
